// File: rtl/led_pwm_breather_pkg.sv
// Shared types and helpers for the LED PWM breather output stage.
package led_pwm_breather_pkg;

    // Ramp/hold phase; encodings are visible on the o_phase port.
    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } phase_t;

    // Largest duty value for a PWM counter of the given width.
    function automatic int duty_max(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

endpackage

// File: rtl/led_pwm_breather_step_tick_gen.sv
// Modulo-CYCLES enabled counter producing a single-cycle tick on its last count.
// Dropping i_en clears the count, so the first tick after re-enable comes
// CYCLES cycles later.
module step_tick_gen #(
    parameter int CYCLES = 65536
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count enabled cycles, wrapping at CYCLES-1; cleared while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (!i_en) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Tick is high for the one enabled cycle on which the counter sits at its last value.
    always_comb begin
        o_tick = i_en && (cnt_q == CNT_LAST);
    end

endmodule

// File: rtl/led_pwm_breather.sv
// LED output stage: PWM-dims one LED with a linear fade, either following a
// slow on/off request or running an autonomous rise/hold/fall/hold breath.
module led_pwm_breather
    import led_pwm_breather_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 65536,
    parameter int HOLD_STEPS  = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_mode,
    input  logic                i_target,
    output logic                o_led,
    output logic [PWM_BITS-1:0] o_duty,
    output logic [1:0]          o_phase
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX    = PWM_BITS'(duty_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] DUTY_MAX_M1 = PWM_BITS'(duty_max(PWM_BITS) - 1);
    localparam logic [PWM_BITS-1:0] DUTY_ONE    = PWM_BITS'(1);
    localparam int                  HOLD_W      = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_STEPS - 1);

    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_q;
    logic                led_q;
    logic [PWM_BITS-1:0] duty_q,  duty_nxt;
    logic [HOLD_W-1:0]   hold_q,  hold_nxt;
    phase_t              phase_q, phase_nxt;

    step_tick_gen #(
        .CYCLES (STEP_CYCLES)
    ) u_step_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .o_tick  (step_tick)
    );

    // Free-running PWM counter and registered LED compare; both blanked while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_q <= '0;
            led_q <= 1'b0;
        end else if (i_en) begin
            pwm_q <= pwm_q + 1'b1;
            led_q <= (pwm_q < duty_q);
        end else begin
            pwm_q <= '0;
            led_q <= 1'b0;
        end
    end

    // Fade state register: duty, phase and hold count only move on a step tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            duty_q  <= '0;
            hold_q  <= '0;
            phase_q <= HOLD_LO;
        end else begin
            duty_q  <= duty_nxt;
            hold_q  <= hold_nxt;
            phase_q <= phase_nxt;
        end
    end

    // Next fade state: breathe sequence or saturating follow of i_target.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        duty_nxt  = duty_q;
        hold_nxt  = hold_q;
        phase_nxt = phase_q;
        if (step_tick) begin
            if (i_mode) begin
                unique case (phase_q)
                    RISE: begin
                        if (duty_q == DUTY_MAX) begin
                            phase_nxt = HOLD_HI;
                            hold_nxt  = '0;
                        end else begin
                            duty_nxt = duty_q + 1'b1;
                            if (duty_q == DUTY_MAX_M1) begin
                                phase_nxt = HOLD_HI;
                                hold_nxt  = '0;
                            end
                        end
                    end
                    HOLD_HI: begin
                        if (hold_q == HOLD_LAST) begin
                            phase_nxt = FALL;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold_q + 1'b1;
                        end
                    end
                    FALL: begin
                        if (duty_q == '0) begin
                            phase_nxt = HOLD_LO;
                            hold_nxt  = '0;
                        end else begin
                            duty_nxt = duty_q - 1'b1;
                            if (duty_q == DUTY_ONE) begin
                                phase_nxt = HOLD_LO;
                                hold_nxt  = '0;
                            end
                        end
                    end
                    HOLD_LO: begin
                        if (hold_q == HOLD_LAST) begin
                            phase_nxt = RISE;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold_q + 1'b1;
                        end
                    end
                endcase
            end else begin
                // Follow mode keeps the hold count clear so breathe entry starts a fresh hold.
                hold_nxt = '0;
                if (i_target) begin
                    if (duty_q != DUTY_MAX) begin
                        duty_nxt = duty_q + 1'b1;
                    end
                    phase_nxt = (duty_q >= DUTY_MAX_M1) ? HOLD_HI : RISE;
                end else begin
                    if (duty_q != '0) begin
                        duty_nxt = duty_q - 1'b1;
                    end
                    phase_nxt = (duty_q <= DUTY_ONE) ? HOLD_LO : FALL;
                end
            end
        end
    end

    // Drive outputs straight from the registered state.
    always_comb begin
        o_led   = led_q;
        o_duty  = duty_q;
        o_phase = phase_q;
    end

endmodule

// File: tb/tb_led_pwm_breather.sv
// Directed testbench for led_pwm_breather with PWM_BITS=4, STEP_CYCLES=4, HOLD_STEPS=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pwm_breather;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       target;
    logic       led;
    logic [3:0] duty;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    led_pwm_breather #(
        .PWM_BITS    (4),
        .STEP_CYCLES (4),
        .HOLD_STEPS  (2)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_mode   (mode),
        .i_target (target),
        .o_led    (led),
        .o_duty   (duty),
        .o_phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing on the following falling edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset with the given inputs; release happens on a falling edge ("cycle 0").
    task automatic do_reset(input logic e, input logic m, input logic t);
        @(negedge clk);
        rst_n  = 1'b0;
        en     = e;
        mode   = m;
        target = t;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; target = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (led !== 1'b0)   begin n_fail++; $display("FAIL rst_led: got %b want 0", led); end
        n_checks++; if (duty !== 4'd0)  begin n_fail++; $display("FAIL rst_duty: got %0d want 0", duty); end
        n_checks++; if (phase !== 2'd3) begin n_fail++; $display("FAIL rst_phase: got %0d want 3", phase); end
        rst_n = 1'b1;
        wait_cycles(1);
        n_checks++; if (led !== 1'b0 || duty !== 4'd0 || phase !== 2'd3)
            begin n_fail++; $display("FAIL rst_release: got led=%b duty=%0d phase=%0d want 0/0/3", led, duty, phase); end
    endtask

    task automatic test_breathe();
        do_reset(1'b1, 1'b1, 1'b0);
        wait_cycles(7);
        n_checks++; if (phase !== 2'd3 || duty !== 4'd0)
            begin n_fail++; $display("FAIL br_c7: got duty=%0d phase=%0d want 0/3", duty, phase); end
        wait_cycles(1);
        n_checks++; if (phase !== 2'd0 || duty !== 4'd0)
            begin n_fail++; $display("FAIL br_c8: got duty=%0d phase=%0d want 0/0", duty, phase); end
        wait_cycles(4);
        n_checks++; if (phase !== 2'd0 || duty !== 4'd1)
            begin n_fail++; $display("FAIL br_c12: got duty=%0d phase=%0d want 1/0", duty, phase); end
        wait_cycles(55);
        n_checks++; if (phase !== 2'd0 || duty !== 4'd14)
            begin n_fail++; $display("FAIL br_c67: got duty=%0d phase=%0d want 14/0", duty, phase); end
        wait_cycles(1);
        n_checks++; if (phase !== 2'd1 || duty !== 4'd15)
            begin n_fail++; $display("FAIL br_c68: got duty=%0d phase=%0d want 15/1", duty, phase); end
        wait_cycles(67);
        n_checks++; if (phase !== 2'd2 || duty !== 4'd1)
            begin n_fail++; $display("FAIL br_c135: got duty=%0d phase=%0d want 1/2", duty, phase); end
        wait_cycles(1);
        n_checks++; if (phase !== 2'd3 || duty !== 4'd0)
            begin n_fail++; $display("FAIL br_c136: got duty=%0d phase=%0d want 0/3", duty, phase); end
    endtask

    task automatic test_follow();
        int cnt;
        do_reset(1'b1, 1'b0, 1'b1);
        wait_cycles(3);
        n_checks++; if (duty !== 4'd0)
            begin n_fail++; $display("FAIL fo_c3: got duty=%0d want 0", duty); end
        wait_cycles(1);
        n_checks++; if (duty !== 4'd1 || phase !== 2'd0)
            begin n_fail++; $display("FAIL fo_c4: got duty=%0d phase=%0d want 1/0", duty, phase); end
        wait_cycles(12);
        n_checks++; if (duty !== 4'd4 || phase !== 2'd0)
            begin n_fail++; $display("FAIL fo_c16: got duty=%0d phase=%0d want 4/0", duty, phase); end
        // Cycles 17..32: pwm 0..15 against duty 4,5,6,7 (4 cycles each) -> 4+1+0+0 high.
        cnt = 0;
        repeat (16) begin @(negedge clk); cnt += int'(led); end
        n_checks++; if (cnt != 5)
            begin n_fail++; $display("FAIL fo_led_ramp: got %0d high want 5", cnt); end
        wait_cycles(128);
        n_checks++; if (duty !== 4'd15 || phase !== 2'd1)
            begin n_fail++; $display("FAIL fo_sat: got duty=%0d phase=%0d want 15/1", duty, phase); end
        cnt = 0;
        repeat (16) begin @(negedge clk); cnt += int'(led); end
        n_checks++; if (cnt != 15)
            begin n_fail++; $display("FAIL fo_led_max: got %0d high want 15", cnt); end
    endtask

    task automatic test_reversal();
        int cnt;
        do_reset(1'b1, 1'b0, 1'b1);
        wait_cycles(28);
        n_checks++; if (duty !== 4'd7)
            begin n_fail++; $display("FAIL rv_c28: got duty=%0d want 7", duty); end
        target = 1'b0;
        wait_cycles(3);
        n_checks++; if (duty !== 4'd7 || phase !== 2'd0)
            begin n_fail++; $display("FAIL rv_c31: got duty=%0d phase=%0d want 7/0", duty, phase); end
        wait_cycles(1);
        n_checks++; if (duty !== 4'd6 || phase !== 2'd2)
            begin n_fail++; $display("FAIL rv_c32: got duty=%0d phase=%0d want 6/2", duty, phase); end
        wait_cycles(23);
        n_checks++; if (duty !== 4'd1 || phase !== 2'd2)
            begin n_fail++; $display("FAIL rv_c55: got duty=%0d phase=%0d want 1/2", duty, phase); end
        wait_cycles(1);
        n_checks++; if (duty !== 4'd0 || phase !== 2'd3)
            begin n_fail++; $display("FAIL rv_c56: got duty=%0d phase=%0d want 0/3", duty, phase); end
        wait_cycles(40);
        cnt = 0;
        repeat (16) begin @(negedge clk); cnt += int'(led); end
        n_checks++; if (duty !== 4'd0 || phase !== 2'd3 || cnt != 0)
            begin n_fail++; $display("FAIL rv_floor: got duty=%0d phase=%0d led_high=%0d want 0/3/0", duty, phase, cnt); end
    endtask

    task automatic test_enable_drop();
        int bad;
        do_reset(1'b1, 1'b0, 1'b1);
        wait_cycles(36);
        // Cycle 36: pwm 3 against duty 8 -> LED on.
        n_checks++; if (duty !== 4'd9 || led !== 1'b1)
            begin n_fail++; $display("FAIL en_c36: got duty=%0d led=%b want 9/1", duty, led); end
        en = 1'b0;
        wait_cycles(1);
        n_checks++; if (led !== 1'b0)
            begin n_fail++; $display("FAIL en_blank: got led=%b want 0", led); end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (led !== 1'b0 || duty !== 4'd9 || phase !== 2'd0) bad++;
        end
        n_checks++; if (bad != 0)
            begin n_fail++; $display("FAIL en_frozen: got %0d bad cycles want 0", bad); end
        en = 1'b1;
        wait_cycles(3);
        n_checks++; if (duty !== 4'd9)
            begin n_fail++; $display("FAIL en_re3: got duty=%0d want 9", duty); end
        wait_cycles(1);
        n_checks++; if (duty !== 4'd10)
            begin n_fail++; $display("FAIL en_re4: got duty=%0d want 10", duty); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b0, 1'b1);
        wait_cycles(42);
        // Cycle 42: pwm 9 against duty 10 -> LED on.
        n_checks++; if (duty !== 4'd10 || led !== 1'b1)
            begin n_fail++; $display("FAIL ar_pre: got duty=%0d led=%b want 10/1", duty, led); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (led !== 1'b0 || duty !== 4'd0 || phase !== 2'd3)
            begin n_fail++; $display("FAIL ar_now: got led=%b duty=%0d phase=%0d want 0/0/3", led, duty, phase); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mode_switch();
        do_reset(1'b1, 1'b0, 1'b1);
        wait_cycles(20);
        n_checks++; if (duty !== 4'd5 || phase !== 2'd0)
            begin n_fail++; $display("FAIL ms_c20: got duty=%0d phase=%0d want 5/0", duty, phase); end
        mode = 1'b1;
        wait_cycles(4);
        n_checks++; if (duty !== 4'd6 || phase !== 2'd0)
            begin n_fail++; $display("FAIL ms_c24: got duty=%0d phase=%0d want 6/0", duty, phase); end
        for (int k = 7; k <= 15; k++) begin
            wait_cycles(4);
            n_checks++; if (duty !== 4'(k))
                begin n_fail++; $display("FAIL ms_ramp: got duty=%0d want %0d", duty, k); end
        end
        n_checks++; if (phase !== 2'd1)
            begin n_fail++; $display("FAIL ms_hold: got phase=%0d want 1", phase); end
        wait_cycles(8);
        n_checks++; if (duty !== 4'd15 || phase !== 2'd2)
            begin n_fail++; $display("FAIL ms_c68: got duty=%0d phase=%0d want 15/2", duty, phase); end
        wait_cycles(4);
        n_checks++; if (duty !== 4'd14 || phase !== 2'd2)
            begin n_fail++; $display("FAIL ms_c72: got duty=%0d phase=%0d want 14/2", duty, phase); end
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 1'b0;
        target = 1'b0;
        test_reset();
        test_breathe();
        test_follow();
        test_reversal();
        test_enable_drop();
        test_async_reset();
        test_mode_switch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
